// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending controller.
// Holds the FSM state enum, BCD limit and the default price rule.
package vend_pkg;

  localparam int BCD_MAX = 9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RELOAD,
    S_DIG1,
    S_DIG2,
    S_CHECK,
    S_PAY,
    S_VEND,
    S_DOOR_WAIT,
    S_DOOR_HELD,
    S_INVALID,
    S_FAILED
  } vend_state_e;

  // Power-up price: one unit per group of four slots,
  // clipped to what COST can show.
  function automatic int price_default(
    input int i,
    input int cost_w
  );
    int p;
    int pmax;
    p    = i / 4 + 1;
    pmax = (1 << cost_w) - 1;
    return (p > pmax) ? pmax : p;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// vend_ctrl_multi_if: keypad/card/door inputs and dispense/display outputs.
// master drives the machine inputs; slave is the controller side.
interface vend_ctrl_multi_if #(
  parameter int NUM_SLOTS = 20,
  parameter int COST_W    = 3,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
);

  logic                 CARD_IN;
  logic                 KEY_PRESS;
  logic [3:0]           ITEM_CODE;
  logic                 VALID_TRAN;
  logic                 DOOR_OPEN;
  logic                 RELOAD;
  logic                 PRICE_WE;
  logic [IDX_W-1:0]     PRICE_ADDR;
  logic [COST_W-1:0]    PRICE_DATA;
  logic                 VEND;
  logic                 INVALID_SEL;
  logic                 FAILED_TRAN;
  logic [COST_W-1:0]    COST;
  logic                 BUSY;
  logic [NUM_SLOTS-1:0] SLOT_EMPTY;

  modport master (
    output CARD_IN, KEY_PRESS, ITEM_CODE,
    output VALID_TRAN, DOOR_OPEN, RELOAD,
    output PRICE_WE, PRICE_ADDR, PRICE_DATA,
    input  VEND, INVALID_SEL, FAILED_TRAN,
    input  COST, BUSY, SLOT_EMPTY
  );

  modport slave (
    input  CARD_IN, KEY_PRESS, ITEM_CODE,
    input  VALID_TRAN, DOOR_OPEN, RELOAD,
    input  PRICE_WE, PRICE_ADDR, PRICE_DATA,
    output VEND, INVALID_SEL, FAILED_TRAN,
    output COST, BUSY, SLOT_EMPTY
  );

endinterface

// File: rtl/vend_timeout_ctr.sv
// vend_timeout_ctr: cycle counter shared by all timed FSM states.
// Ports: CLK, RESET, clr (state change), en (timed state), expired.
module vend_timeout_ctr
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Held at zero outside timed states so every entry starts fresh.
  always_ff @(posedge CLK) begin
    if (RESET || clr || !en)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + CW'(1);
  end

  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: card-paid vending controller with stock and prices.
// Ports: CLK, RESET (sync, high), bus (vend_ctrl_multi_if.slave).
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS  = 20,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10,
  parameter int COST_W     = 3,
  parameter int TIMEOUT    = 5,
  parameter int IDX_W      = $clog2(NUM_SLOTS)
) (
  input  logic CLK,
  input  logic RESET,
  vend_ctrl_multi_if.slave bus
);

  localparam int SMAX = (1 << STOCK_W) - 1;
  localparam logic [STOCK_W-1:0] RELOAD_V =
    (RELOAD_QTY > SMAX) ? STOCK_W'(SMAX)
                        : STOCK_W'(RELOAD_QTY);

  vend_state_e state_q, state_d;

  logic [STOCK_W-1:0] stock_q [NUM_SLOTS];
  logic [COST_W-1:0]  price_q [NUM_SLOTS];
  logic [COST_W-1:0]  cost_r;
  logic [3:0]         dig1_q, dig2_q;

  logic [7:0]         idx;
  logic               in_range;
  logic [IDX_W-1:0]   slot;
  logic               sel_ok;
  logic               timed;
  logic               tmo;

  // Two BCD digits form the slot number; worst case 15*10+15.
  assign idx = {4'd0, dig1_q} * 8'd10 + {4'd0, dig2_q};

  assign in_range = (dig1_q <= 4'(BCD_MAX))
                 && (dig2_q <= 4'(BCD_MAX))
                 && (idx < 8'(NUM_SLOTS));

  // Slot is only used once in_range holds; parked at 0 otherwise.
  assign slot = in_range ? idx[IDX_W-1:0] : '0;

  assign sel_ok = in_range && (stock_q[slot] != '0);

  assign timed = (state_q == S_DIG1)
              || (state_q == S_DIG2)
              || (state_q == S_PAY)
              || (state_q == S_DOOR_WAIT);

  vend_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (state_d != state_q),
    .en      (timed),
    .expired (tmo)
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Card removal beats a key/payment; an event beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.RELOAD)
          state_d = S_RELOAD;
        else if (bus.CARD_IN)
          state_d = S_DIG1;
      end
      S_RELOAD:
        state_d = S_IDLE;
      S_DIG1: begin
        if (!bus.CARD_IN)
          state_d = S_IDLE;
        else if (bus.KEY_PRESS)
          state_d = S_DIG2;
        else if (tmo)
          state_d = S_INVALID;
      end
      S_DIG2: begin
        if (!bus.CARD_IN)
          state_d = S_IDLE;
        else if (bus.KEY_PRESS)
          state_d = S_CHECK;
        else if (tmo)
          state_d = S_INVALID;
      end
      S_CHECK:
        state_d = sel_ok ? S_PAY : S_INVALID;
      S_PAY: begin
        if (!bus.CARD_IN)
          state_d = S_IDLE;
        else if (bus.VALID_TRAN)
          state_d = S_VEND;
        else if (tmo)
          state_d = S_FAILED;
      end
      S_VEND:
        state_d = S_DOOR_WAIT;
      S_DOOR_WAIT: begin
        if (bus.DOOR_OPEN)
          state_d = S_DOOR_HELD;
        else if (tmo)
          state_d = S_IDLE;
      end
      S_DOOR_HELD: begin
        if (!bus.DOOR_OPEN)
          state_d = S_IDLE;
      end
      S_INVALID,
      S_FAILED:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dig1_q <= '0;
      dig2_q <= '0;
    end else begin
      if (state_q == S_DIG1 && bus.KEY_PRESS)
        dig1_q <= bus.ITEM_CODE;
      if (state_q == S_DIG2 && bus.KEY_PRESS)
        dig2_q <= bus.ITEM_CODE;
    end
  end

  // CHECK has already rejected empty slots, so no underflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        stock_q[i] <= '0;
    end else if (state_q == S_RELOAD) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        stock_q[i] <= RELOAD_V;
    end else if (state_q == S_VEND) begin
      stock_q[slot] <= stock_q[slot] - STOCK_W'(1);
    end
  end

  // Writes to addresses past the last slot are dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        price_q[i] <= COST_W'(price_default(i, COST_W));
    end else if (bus.PRICE_WE
              && (32'(bus.PRICE_ADDR) < NUM_SLOTS)) begin
      price_q[bus.PRICE_ADDR] <= bus.PRICE_DATA;
    end
  end

  // Price is frozen at CHECK; later writes wait for the next sale.
  always_ff @(posedge CLK) begin
    if (RESET)
      cost_r <= '0;
    else if (state_q == S_CHECK && sel_ok)
      cost_r <= price_q[slot];
  end

  assign bus.VEND        = (state_q == S_VEND);
  assign bus.INVALID_SEL = (state_q == S_INVALID);
  assign bus.FAILED_TRAN = (state_q == S_FAILED);
  assign bus.BUSY        = (state_q != S_IDLE);
  assign bus.COST        = (state_q == S_PAY) ? cost_r : '0;

  always_comb begin
    bus.SLOT_EMPTY = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      bus.SLOT_EMPTY[i] = (stock_q[i] == '0);
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed and random transactions for vend_ctrl_multi.
// A transaction-level model of stock and prices predicts every pulse.
module tb_vend_ctrl_multi;

  localparam int NS  = 20;
  localparam int SW  = 4;
  localparam int RQ  = 10;
  localparam int CW  = 3;
  localparam int TO  = 5;
  localparam int IW  = 5;

  logic CLK;
  logic RESET;

  int n_tests;
  int n_fail;

  int stock_m [NS];
  int price_m [NS];

  vend_ctrl_multi_if #(
    .NUM_SLOTS (NS),
    .COST_W    (CW),
    .IDX_W     (IW)
  ) vif ();

  vend_ctrl_multi #(
    .NUM_SLOTS  (NS),
    .STOCK_W    (SW),
    .RELOAD_QTY (RQ),
    .COST_W     (CW),
    .TIMEOUT    (TO),
    .IDX_W      (IW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (vif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] empty_m();
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < NS; i++)
      e[i] = (stock_m[i] == 0);
    return e;
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {vif.VEND, vif.INVALID_SEL, vif.FAILED_TRAN}, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      stock_m[i] = 0;
      price_m[i] = (i / 4 + 1 > 7) ? 7 : i / 4 + 1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    model_reset();
    chk("rst_busy", vif.BUSY, 0);
    chk_quiet("rst_pulse");
    chk("rst_cost", vif.COST, 0);
    chk("rst_empty", vif.SLOT_EMPTY, empty_m());
  endtask

  task automatic do_reload();
    vif.RELOAD = 1'b1;
    step();
    vif.RELOAD = 1'b0;
    chk("rl_busy", vif.BUSY, 1);
    step();
    for (int i = 0; i < NS; i++)
      stock_m[i] = RQ;
    chk("rl_idle", vif.BUSY, 0);
    chk("rl_empty", vif.SLOT_EMPTY, empty_m());
  endtask

  task automatic price_wr(input int a, input int d);
    vif.PRICE_WE   = 1'b1;
    vif.PRICE_ADDR = IW'(a);
    vif.PRICE_DATA = CW'(d);
    step();
    vif.PRICE_WE = 1'b0;
    if (a < NS)
      price_m[a] = d;
  endtask

  // kind 0 key, 1 payment, 2 door; event after g waiting cycles.
  // res: 0 event taken, 1 timed out, 2 card pulled.
  task automatic phase(
    input  int         kind,
    input  int         g,
    input  logic [3:0] dig,
    input  bit         cancel,
    input  int         cost,
    output int         res
  );
    bit done;
    done = 1'b0;
    res  = 0;
    for (int i = 0; i < TO && !done; i++) begin
      chk("ph_busy", vif.BUSY, 1);
      chk_quiet("ph_pulse");
      if (kind == 1)
        chk("pay_cost", vif.COST, cost);
      if (i == g) begin
        if (cancel) begin
          vif.CARD_IN = 1'b0;
          res = 2;
        end else if (kind == 0) begin
          vif.KEY_PRESS = 1'b1;
          vif.ITEM_CODE = dig;
        end else if (kind == 1) begin
          vif.VALID_TRAN = 1'b1;
        end else begin
          vif.DOOR_OPEN = 1'b1;
        end
        step();
        vif.KEY_PRESS  = 1'b0;
        vif.VALID_TRAN = 1'b0;
        vif.ITEM_CODE  = 4'($urandom_range(0, 15));
        done = 1'b1;
      end else begin
        step();
        if (i == TO - 1)
          res = 1;
      end
    end
  endtask

  // cancel_at: 0 none, 1 DIG1, 2 DIG2, 3 PAY.
  // pw >= 0 rewrites this slot's price while in PAY.
  task automatic txn(
    input logic [3:0] d1,
    input logic [3:0] d2,
    input int g1, input int g2, input int gp,
    input int gd, input int hold,
    input int cancel_at,
    input int pw
  );
    int idx;
    bit ok;
    int res;
    int c;
    idx = int'(d1) * 10 + int'(d2);
    ok  = 1'b0;
    if (d1 <= 9 && d2 <= 9 && idx < NS)
      ok = (stock_m[idx] > 0);
    chk("tx_idle", vif.BUSY, 0);
    vif.CARD_IN = 1'b1;
    step();
    phase(0, g1, d1, cancel_at == 1, 0, res);
    if (res == 0)
      phase(0, g2, d2, cancel_at == 2, 0, res);
    if (res == 2) begin
      chk("cxl_busy", vif.BUSY, 0);
      chk_quiet("cxl_pulse");
    end else if (res == 1) begin
      chk("key_tmo_inv", vif.INVALID_SEL, 1);
      vif.CARD_IN = 1'b0;
      step();
      chk("key_tmo_idle", vif.BUSY, 0);
      chk_quiet("key_tmo_pulse");
    end else begin
      chk("chk_busy", vif.BUSY, 1);
      chk("chk_cost", vif.COST, 0);
      chk_quiet("chk_pulse");
      step();
      if (!ok) begin
        chk("sel_inv", vif.INVALID_SEL, 1);
        chk("sel_inv_v", vif.VEND, 0);
        vif.CARD_IN = 1'b0;
        step();
        chk("sel_inv_idle", vif.BUSY, 0);
        chk("sel_inv_1cyc", vif.INVALID_SEL, 0);
      end else begin
        c = price_m[idx];
        if (pw >= 0) begin
          vif.PRICE_WE   = 1'b1;
          vif.PRICE_ADDR = IW'(idx);
          vif.PRICE_DATA = CW'(pw);
        end
        phase(1, gp, 0, cancel_at == 3, c, res);
        vif.PRICE_WE = 1'b0;
        if (pw >= 0)
          price_m[idx] = pw;
        if (res == 2) begin
          chk("pcxl_busy", vif.BUSY, 0);
          chk_quiet("pcxl_pulse");
        end else if (res == 1) begin
          chk("pay_failed", vif.FAILED_TRAN, 1);
          chk("pay_fail_cost", vif.COST, 0);
          vif.CARD_IN = 1'b0;
          step();
          chk("pay_fail_1cyc", vif.FAILED_TRAN, 0);
          chk("pay_fail_idle", vif.BUSY, 0);
        end else begin
          chk("vend_hi", vif.VEND, 1);
          chk("vend_cost", vif.COST, 0);
          stock_m[idx]--;
          vif.CARD_IN = 1'b0;
          step();
          chk("vend_1cyc", vif.VEND, 0);
          chk("vend_empty", vif.SLOT_EMPTY, empty_m());
          phase(2, gd, 0, 1'b0, 0, res);
          if (res == 1) begin
            chk("door_tmo_idle", vif.BUSY, 0);
          end else begin
            for (int h = 0; h < hold; h++) begin
              chk("held_busy", vif.BUSY, 1);
              chk_quiet("held_pulse");
              step();
            end
            vif.DOOR_OPEN = 1'b0;
            chk("held_last", vif.BUSY, 1);
            step();
            chk("door_idle", vif.BUSY, 0);
          end
        end
      end
    end
    vif.CARD_IN = 1'b0;
    step();
    chk("tx_end_busy", vif.BUSY, 0);
    chk("tx_end_empty", vif.SLOT_EMPTY, empty_m());
  endtask

  int r;
  int g1, g2, gp, gd, cx, pw;
  logic [3:0] d1, d2;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET           = 1'b1;
    vif.CARD_IN     = 1'b0;
    vif.KEY_PRESS   = 1'b0;
    vif.ITEM_CODE   = 4'd0;
    vif.VALID_TRAN  = 1'b0;
    vif.DOOR_OPEN   = 1'b0;
    vif.RELOAD      = 1'b0;
    vif.PRICE_WE    = 1'b0;
    vif.PRICE_ADDR  = '0;
    vif.PRICE_DATA  = '0;

    do_reset();

    // empty machine rejects 02
    txn(4'd0, 4'd2, 0, 0, 0, 0, 0, 0, -1);

    // first sale: 13 at price 4
    do_reload();
    txn(4'd1, 4'd3, 0, 0, 0, 0, 0, 0, -1);

    // index out of range, then non-BCD digit
    txn(4'd2, 4'd5, 0, 0, 0, 0, 0, 0, -1);
    txn(4'd1, 4'd10, 0, 0, 0, 0, 0, 0, -1);

    // payment timeout, then payment on the last allowed cycle
    txn(4'd0, 4'd7, 0, 0, TO, 0, 0, 0, -1);
    txn(4'd0, 4'd7, 0, 0, TO - 1, 0, 0, 0, -1);

    // keypad timeout and last-cycle key
    txn(4'd0, 4'd4, TO, 0, 0, 0, 0, 0, -1);
    txn(4'd0, 4'd4, TO - 1, TO - 1, 0, 0, 0, 0, -1);

    // new price honoured; write during PAY does not move COST
    price_wr(7, 6);
    txn(4'd0, 4'd7, 0, 0, 2, 0, 0, 0, 2);
    txn(4'd0, 4'd7, 0, 0, 0, 0, 0, 0, -1);

    // card pulled in DIG2 and in PAY
    txn(4'd0, 4'd9, 0, 1, 0, 0, 0, 2, -1);
    txn(4'd0, 4'd9, 0, 0, 1, 0, 0, 3, -1);

    // long door hold, then door never opens
    txn(4'd1, 4'd1, 0, 0, 0, 0, 8, 0, -1);
    txn(4'd1, 4'd1, 0, 0, 0, TO, 0, 0, -1);

    // RELOAD beats CARD_IN and leaves the machine idle
    vif.RELOAD  = 1'b1;
    vif.CARD_IN = 1'b1;
    step();
    vif.RELOAD = 1'b0;
    chk("rlc_busy", vif.BUSY, 1);
    step();
    for (int i = 0; i < NS; i++)
      stock_m[i] = RQ;
    chk("rlc_idle", vif.BUSY, 0);
    vif.CARD_IN = 1'b0;
    step();

    // drain slot 0, then one more attempt is refused
    for (int k = 0; k < RQ; k++)
      txn(4'd0, 4'd0, 0, 0, 0, 0, 0, 0, -1);
    chk("slot0_empty", vif.SLOT_EMPTY[0], 1);
    txn(4'd0, 4'd0, 0, 0, 0, 0, 0, 0, -1);

    // reset in the middle of a selection
    vif.CARD_IN = 1'b1;
    step();
    vif.KEY_PRESS = 1'b1;
    vif.ITEM_CODE = 4'd1;
    step();
    vif.KEY_PRESS = 1'b0;
    vif.CARD_IN   = 1'b0;
    do_reset();

    // random mix
    do_reload();
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        do_reload();
      else if (r == 1)
        price_wr($urandom_range(0, 31), $urandom_range(0, 7));
      d1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                      : 4'($urandom_range(0, 2));
      d2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                      : 4'($urandom_range(0, 9));
      g1 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO) : 0;
      g2 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO) : 0;
      gp = $urandom_range(0, TO);
      gd = $urandom_range(0, TO);
      cx = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      pw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      txn(d1, d2, g1, g2, gp, gd, $urandom_range(0, 3), cx, pw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending-machine controller: one card-paid transaction at a time over `NUM_SLOTS` item slots. It adds per-slot stock tracking, a runtime-writable per-slot price table, a configurable timeout length and card-removal cancel. It sits between the keypad/card-reader/door sensor inputs and the dispense/display outputs, replacing the fixed 20-slot controller.

## Interface
Parameters:
- `NUM_SLOTS`, 20: number of slots, 1..100; slot index = 10·first digit + second digit.
- `STOCK_W`, 4: stock counter width per slot.
- `RELOAD_QTY`, 10: stock loaded on reload; saturates at 2^STOCK_W−1.
- `COST_W`, 3: price/COST width.
- `TIMEOUT`, 5: cycles allowed for each awaited event, ≥2.
- `IDX_W`, $clog2(NUM_SLOTS): PRICE_ADDR width.

Ports:
- `CLK` in 1: clock, all logic on rising edge.
- `RESET` in 1: synchronous, active-high.
- `CARD_IN` in 1: card present; a low level cancels an open transaction.
- `KEY_PRESS` in 1: one-cycle strobe; ITEM_CODE is valid in the same cycle.
- `ITEM_CODE` in 4: BCD digit.
- `VALID_TRAN` in 1: payment approved.
- `DOOR_OPEN` in 1: dispense door sensor.
- `RELOAD` in 1: refill all slots.
- `PRICE_WE` in 1: price table write strobe.
- `PRICE_ADDR` in IDX_W: slot to write.
- `PRICE_DATA` in COST_W: new price.
- `VEND` out 1: dispense pulse.
- `INVALID_SEL` out 1: selection rejected pulse.
- `FAILED_TRAN` out 1: payment timeout pulse.
- `COST` out COST_W: price of the selected slot.
- `BUSY` out 1: high in every state except IDLE.
- `SLOT_EMPTY` out NUM_SLOTS: bit i is high when stock[i]==0.

## Operation
- States and transitions:
  - IDLE:
    - RELOAD → RELOAD_ST.
    - Otherwise CARD_IN → DIG1.
  - RELOAD_ST: all stock ← RELOAD_QTY; → IDLE.
  - DIG1: KEY_PRESS latches digit 1 → DIG2.
  - DIG2: KEY_PRESS latches digit 2 → CHECK.
  - CHECK:
    - → INVALID if either digit > 9, or index ≥ NUM_SLOTS, or stock[index]==0.
    - Otherwise COST_R ← price[index] → PAY.
  - PAY: VALID_TRAN → VEND_ST.
  - VEND_ST: stock[index] decrements; → DOOR_WAIT.
  - DOOR_WAIT: DOOR_OPEN → DOOR_HELD.
  - DOOR_HELD: stays while DOOR_OPEN; → IDLE when DOOR_OPEN falls.
  - INVALID → IDLE.
  - FAILED → IDLE.
- Timeouts in DIG1, DIG2 and PAY:
  - No event within TIMEOUT cycles of state entry → INVALID from DIG1/DIG2, FAILED from PAY.
  - No DOOR_OPEN within TIMEOUT cycles in DOOR_WAIT → IDLE. The item is still counted as vended.
- Cancel: CARD_IN low in DIG1, DIG2 or PAY → IDLE, with no output pulse and no stock change.
- Moore outputs, decoded from the state register:
  - VEND=1 only in VEND_ST.
  - INVALID_SEL=1 only in INVALID.
  - FAILED_TRAN=1 only in FAILED.
  - COST=COST_R in PAY, otherwise 0.
- RELOAD is ignored outside IDLE. RELOAD and CARD_IN together in IDLE: RELOAD wins.
- Price writes are accepted in any state and take effect next cycle. COST_R is captured in CHECK, so a write during PAY does not change COST.
- Stock decrement never underflows, because CHECK already rejects empty slots.

## Timing
- RESET, sampled at an edge:
  - State → IDLE, all stock ← 0, timeout counter ← 0, COST_R ← 0.
  - Price table ← default: price[i] = i/4 + 1, saturated at 2^COST_W−1.
  - All outputs 0 the following cycle; SLOT_EMPTY all ones.
- RESET mid-transaction aborts with no pulse.
- The timeout counter clears on every state change and increments each cycle in a timed state. When it reaches TIMEOUT−1 with no event, the next edge takes the timeout exit.
- An event in the final allowed cycle wins over the timeout.
- Latency from the CARD_IN edge to DIG1 is 1 cycle.
- Minimum transaction, card to VEND high, is 5 cycles: DIG1, DIG2, CHECK, PAY, VEND_ST, each with 1-cycle responses.
- VEND, INVALID_SEL and FAILED_TRAN are exactly 1 cycle wide.
- SLOT_EMPTY updates the cycle after a stock change.

## Structure
- Package `vend_pkg`: state enum, `price_default(i)` function, `BCD_MAX`=9 constant.
- Sub-module `vend_timeout_ctr`:
  - Parameter TIMEOUT; inputs `clr`, `en`; output `expired`, asserted when count==TIMEOUT−1 and `en` is high.
  - One instance, shared by all timed states.
- Stock and price arrays are flops inside the top module.

## Test plan
- Reset, then RELOAD, card in, keys 1 then 3, VALID_TRAN next cycle → COST=4 in PAY; VEND pulses 1 cycle; stock[13] goes 10→9.
- Reset without reload, card in, keys 0 then 2 → INVALID_SEL pulses because stock is 0; returns to IDLE.
- After reload, keys 2 then 5 (index 25 ≥ 20) → INVALID_SEL. Keys 1 then 10 (BCD > 9) → INVALID_SEL.
- After reload, select 07, hold VALID_TRAN low → FAILED_TRAN in cycle TIMEOUT+1 after PAY entry. Same test with VALID_TRAN on the last allowed cycle → VEND instead.
- Write price[7]=6 with PRICE_WE, then select 07 → COST=6. A write of price[7]=2 during PAY leaves COST at 6.
- Drop CARD_IN during DIG2 → IDLE with no pulses. Hold DOOR_OPEN for 8 cycles after VEND → BUSY stays high until DOOR_OPEN falls. Vend 10 times from slot 0 → SLOT_EMPTY[0]=1 and the next select of 00 is rejected.
